// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage
// Purpose : Pipeline memory-access stage. Issues aligned loads/stores over a
//           single-outstanding req/ack port, extends load data, stalls the
//           upstream while a transaction is open, and owns the MEM/WB register.
// Rev     : 1.0  initial release
// ============================================================================
module mem_stage #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_store_data,
   input  logic [4:0]  i_rd,
   input  logic        i_ctrl_valid,
   input  logic        i_ctrl_bubble,
   input  logic        i_ctrl_mem_read,
   input  logic        i_ctrl_mem_write,
   input  logic        i_ctrl_wb_en,
   input  logic [2:0]  i_ctrl_funct3,
   output logic        o_stall,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_bmask,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_wb_valid,
   output logic        o_wb_en,
   output logic [4:0]  o_wb_rd,
   output logic [31:0] o_wb_data,
   output logic [31:0] o_wb_pc,
   output logic        o_misaligned,
   output logic        o_bus_err
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drop_q, drop_d, err_q, err_d;
   logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d, pc_q, pc_d;
   logic [3:0]       bmask_q, bmask_d;
   logic             we_q, we_d, wben_q, wben_d;
   logic [2:0]       f3_q, f3_d;
   logic [4:0]       rd_q, rd_d;

   logic             wb_valid_q, wb_valid_d, wb_en_q, wb_en_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [31:0]      wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
   logic             mis_q, mis_d, berr_q, berr_d;

   logic             w_live, w_mem, w_we, w_size_w, w_size_h, w_misal, w_start;
   logic [31:0]      w_wdata, w_ext;
   logic [3:0]       w_bmask;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;

   // Decode of the incoming EX/MEM op; funct3[1] set means word (incl. 011/110/111)
   assign w_live   = i_ctrl_valid && !i_ctrl_bubble;
   assign w_mem    = w_live && (i_ctrl_mem_read || i_ctrl_mem_write);
   assign w_we     = !i_ctrl_mem_read;
   assign w_size_w = i_ctrl_funct3[1];
   assign w_size_h = !i_ctrl_funct3[1] && i_ctrl_funct3[0];
   assign w_misal  = (w_size_h && i_alu_result[0]) ||
                     (w_size_w && (i_alu_result[1:0] != 2'b00));
   assign w_start  = (state_q == S_IDLE) && w_mem && !w_misal && !i_flush;

   // Store lane replication and byte enables; loads enable every lane
   always_comb begin
      w_wdata = i_store_data;
      w_bmask = 4'hF;
      if (!w_size_w && !w_size_h) begin
         w_wdata = {4{i_store_data[7:0]}};
         if (w_we) w_bmask = 4'b0001 << i_alu_result[1:0];
      end else if (w_size_h) begin
         w_wdata = {2{i_store_data[15:0]}};
         if (w_we) w_bmask = 4'b0011 << i_alu_result[1:0];
      end
   end

   // Lane select and sign/zero extension of the returned read word
   always_comb begin
      case (addr_q[1:0])
         2'd0:    w_byte = i_dmem_rdata[7:0];
         2'd1:    w_byte = i_dmem_rdata[15:8];
         2'd2:    w_byte = i_dmem_rdata[23:16];
         default: w_byte = i_dmem_rdata[31:24];
      endcase
      w_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      case (f3_q)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'd0, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'd0, w_half};
         default: w_ext = i_dmem_rdata;
      endcase
   end

   // Next-state, handshake outputs and MEM/WB next value (bubble by default)
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drop_d     = drop_q;
      err_d      = err_q;
      ldata_d    = ldata_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      bmask_d    = bmask_q;
      we_d       = we_q;
      wben_d     = wben_q;
      f3_d       = f3_q;
      rd_d       = rd_q;
      pc_d       = pc_q;
      o_stall    = 1'b0;
      o_dmem_req = 1'b0;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      wb_rd_d    = 5'd0;
      wb_data_d  = 32'd0;
      wb_pc_d    = 32'd0;
      mis_d      = 1'b0;
      berr_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_start) begin
               addr_d  = i_alu_result;
               wdata_d = w_wdata;
               bmask_d = w_bmask;
               we_d    = w_we;
               wben_d  = i_ctrl_wb_en;
               f3_d    = i_ctrl_funct3;
               rd_d    = i_rd;
               pc_d    = i_pc;
               cnt_d   = '0;
               drop_d  = 1'b0;
               err_d   = 1'b0;
               ldata_d = 32'd0;
               o_stall = 1'b1;
               state_d = S_REQ;
            end else if (!i_flush && w_live) begin
               // Either a non-memory op or a misaligned access (traps, no bus)
               wb_valid_d = 1'b1;
               wb_rd_d    = i_rd;
               wb_pc_d    = i_pc;
               wb_data_d  = i_alu_result;
               if (w_mem) begin
                  mis_d = 1'b1;
               end else begin
                  wb_en_d = i_ctrl_wb_en;
               end
            end
         end
         S_REQ: begin
            o_dmem_req = 1'b1;
            o_stall    = 1'b1;
            if (i_flush) drop_d = 1'b1;
            if (i_dmem_ack) begin
               ldata_d = w_ext;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // A flushed in-flight op completes on the bus but retires as a bubble
            if (!i_flush && !drop_q) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_pc_d    = pc_q;
               wb_en_d    = !we_q && wben_q && !err_q;
               wb_data_d  = (!we_q && !err_q) ? ldata_q : 32'd0;
               berr_d     = err_q;
            end
            drop_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = {addr_q[31:2], 2'b00};
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_bmask = bmask_q;
   assign o_wb_valid   = wb_valid_q;
   assign o_wb_en      = wb_en_q;
   assign o_wb_rd      = wb_rd_q;
   assign o_wb_data    = wb_data_q;
   assign o_wb_pc      = wb_pc_q;
   assign o_misaligned = mis_q;
   assign o_bus_err    = berr_q;

   // State, request payload and MEM/WB registers; reset forgets any open transaction
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
         ldata_q    <= 32'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         bmask_q    <= 4'd0;
         we_q       <= 1'b0;
         wben_q     <= 1'b0;
         f3_q       <= 3'd0;
         rd_q       <= 5'd0;
         pc_q       <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         wb_pc_q    <= 32'd0;
         mis_q      <= 1'b0;
         berr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
         ldata_q    <= ldata_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         bmask_q    <= bmask_d;
         we_q       <= we_d;
         wben_q     <= wben_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
         pc_q       <= pc_d;
         wb_valid_q <= wb_valid_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_pc_q    <= wb_pc_d;
         mis_q      <= mis_d;
         berr_q     <= berr_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the EX/MEM pipeline register and writeback. Consumes the EX/MEM register's outputs, performs loads/stores over a single-outstanding req/ack data-memory port with byte-lane alignment and load sign/zero extension, and stalls the upstream pipeline while a bus transaction is pending. The block also contains the registered MEM/WB boundary: every result reaches writeback one clock after this stage completes.

## Interface
- TIMEOUT_CYC, 16: REQ-state cycles without `i_dmem_ack` before bus error (≥1)
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_flush  in  1  discard the instruction currently in this stage
- i_pc, i_alu_result, i_store_data  in  32 each  from EX/MEM; alu_result is address for memory ops
- i_rd  in  5  destination register
- i_ctrl_valid, i_ctrl_bubble, i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_wb_en  in  1 each  EX/MEM control
- i_ctrl_funct3  in  3  access size/sign
- o_stall  out  1  hold EX/MEM and all earlier stages (combinational)
- o_dmem_req, o_dmem_we  out  1 each  request valid / write
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_bmask  out  4  byte enables
- i_dmem_ack  in  1  transaction complete; rdata valid same cycle
- i_dmem_rdata  in  32  read word
- o_wb_valid, o_wb_en  out  1 each  MEM/WB valid / register write enable
- o_wb_rd  out  5; o_wb_data, o_wb_pc  out  32 each
- o_misaligned, o_bus_err  out  1 each  trap flags, valid with o_wb_valid

## Operation
- Live op: `i_ctrl_valid && !i_ctrl_bubble`. Mem op: live && (mem_read || mem_write); mem_read takes priority if both are set.
- Sizes (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use funct3[1:0]. Codes 011/110/111 are treated as W.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. No bus request is issued; the op retires next edge with o_misaligned=1, o_wb_en=0, and no stall.
- Store lanes: B gives wdata={4{d[7:0]}}, bmask=4'b0001<<addr[1:0]. H gives wdata={2{d[15:0]}}, bmask=4'b0011<<addr[1:0]. W gives wdata=d, bmask=4'hF. Loads drive bmask=4'hF.
- Load extract: select byte at addr[1:0] or half at addr[1]. B/H sign-extend; BU/HU zero-extend.
- FSM IDLE → REQ → DONE → IDLE.
  - IDLE: an aligned mem op latches addr/wdata/bmask/we/funct3/rd/pc/lane into request registers, clears the counter, moves to REQ, and asserts o_stall this cycle.
  - REQ: o_dmem_req=1, payload held stable. On i_dmem_ack, capture the extended load data and move to DONE. Otherwise increment the counter; at counter==TIMEOUT_CYC-1 without ack, set the bus-error flag and move to DONE. o_stall=1.
  - DONE: o_stall=0 and o_dmem_req=0. The MEM/WB register loads the result; return to IDLE. The upstream advances on this edge.
- MEM/WB register: loaded every cycle in which o_stall=0.
  - Non-mem live op: o_wb_data=i_alu_result.
  - Load: o_wb_data = extended data, o_wb_en = i_ctrl_wb_en && !err.
  - Store: o_wb_en=0.
  - Bubble or non-live input: o_wb_valid=0, o_wb_en=0, o_wb_data=0, o_wb_rd=0.
  - While o_stall=1 the register loads a bubble, so no duplicate retirement occurs.
- Flush:
  - In IDLE or DONE, the MEM/WB register loads a bubble.
  - In REQ, the transaction is not abandoned. A sticky drop flag is set, the FSM still waits for ack or timeout, and DONE retires a bubble. No trap flag is raised.
- The bus-error op retires with o_bus_err=1 and o_wb_en=0.

## Timing
- Reset (async assert, sync release) clears all outputs and registers to 0, FSM to IDLE, counter and drop flag to 0. If asserted mid-REQ, o_dmem_req drops immediately and the transaction is forgotten.
- Non-mem or misaligned op: 0 stall cycles; visible on o_wb_* one edge after presentation.
- Memory op with ack in first REQ cycle (cycle N arrives):
  - N: IDLE, stall=1.
  - N+1: REQ, req=1, ack=1.
  - N+2: DONE, stall=0.
  - N+3: o_wb_valid=1.
  - Total stall cycles: 2.
- Each extra wait cycle adds one stall cycle.
- Timeout: exactly TIMEOUT_CYC REQ cycles.
- Back-to-back mem ops: the second op enters IDLE on the edge leaving DONE; no req gap other than the IDLE cycle.

## Test plan
- ALU op, alu_result=0x1234, rd=5, wb_en=1 → next edge: o_wb_valid=1, o_wb_data=0x1234, o_wb_rd=5, o_stall never high.
- LB addr=0x1003, ack after 2 wait cycles with rdata=0x80FFFFFF → req addr=0x1000, bmask=F; stall for 4 cycles; o_wb_data=0xFFFFFF80. LBU from the same address and data → 0x00000080.
- SH addr=0x2002, store_data=0xAAAA5678 → wdata=0x56785678, bmask=4'b1100, we=1; then o_wb_valid=1, o_wb_en=0.
- LW addr=0x3001 → no req, o_misaligned=1, o_wb_en=0, no stall.
- Load with ack never asserted, TIMEOUT_CYC=16 → 16 REQ cycles, then o_bus_err=1, o_wb_en=0, FSM returns to IDLE.
- Flush during REQ, ack 3 cycles later → req held until ack, retire bubble (o_wb_valid=0). Separately, assert reset mid-REQ → all outputs 0 immediately, FSM in IDLE.
